uart_rx_os: RTL
===============

UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal 5..9).
REQ-002 SHALL have parameter DIV_W, default 16, meaning width of the baud_div input.
REQ-003 SHALL have port clk, input, 1, meaning the single system clock.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-005 SHALL have port rx, input, 1, meaning the asynchronous serial line, idle high.
REQ-006 SHALL have port baud_div, input, DIV_W, meaning clk cycles per 1/16-bit sample tick.
REQ-007 SHALL have port parity_mode, input, 2, meaning 00 none, 01 even, 10 odd, 11 none.
REQ-008 SHALL have port stop2, input, 1, meaning 1 = two stop bits, 0 = one stop bit.
REQ-009 SHALL have port rx_data, output, DATA_BITS, meaning the received word, LSB = first bit on the line.
REQ-010 SHALL have port rx_valid, output, 1, meaning rx_data, rx_perr and rx_ferr hold a frame.
REQ-011 SHALL have port rx_ready, input, 1, meaning the consumer accepts the frame.
REQ-012 SHALL have port rx_perr, output, 1, meaning parity error for the held frame.
REQ-013 SHALL have port rx_ferr, output, 1, meaning framing error (a stop bit sampled low) for the held frame.
REQ-014 SHALL have port overrun, output, 1, meaning a one-cycle pulse when a frame is dropped.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-016 SHALL generate a sample tick every max(baud_div,1) clk cycles; the tick counter SHALL restart at start-edge detection.
REQ-017 SHALL sample 16 ticks per bit (ticks 0..15) and take each bit value as the majority of ticks 7, 8 and 9.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 IDLE -> START on a synchronized high-to-low transition; baud_div, parity_mode and stop2 SHALL be latched at this edge and held for the whole frame.
REQ-020 START: if the start-bit majority is high, SHALL return to IDLE with no output (glitch rejection); otherwise SHALL go to DATA at tick 15.
REQ-021 DATA SHALL shift in DATA_BITS bits, LSB first, then go to PARITY if parity is enabled, else to STOP.
REQ-022 PARITY SHALL set the frame parity error when the XOR of the data bits and the parity bit is 1 (even mode) or 0 (odd mode).
REQ-023 STOP SHALL check one stop bit, or two if stop2 is latched; any stop-bit majority of 0 SHALL set the frame framing error.
REQ-024 At the tick-9 sample of the final stop bit, SHALL complete the frame and return to IDLE in the same cycle, so a following start edge is detectable within half a bit.
REQ-025 On completion with rx_valid low, or with rx_valid and rx_ready both high, SHALL load rx_data, rx_perr and rx_ferr and assert rx_valid on the next clk edge.
REQ-026 On completion with rx_valid high and rx_ready low, SHALL discard the new frame, keep the held outputs unchanged, and pulse overrun for 1 cycle.
REQ-027 SHALL deassert rx_valid on the clk edge after the cycle in which rx_valid and rx_ready are both high, unless REQ-025 reloads in that same cycle.
REQ-028 SHALL keep rx_data, rx_perr and rx_ferr stable while rx_valid is high and rx_ready is low.
REQ-029 SHALL treat a change of baud_div, parity_mode or stop2 mid-frame as having no effect until the next start edge.

Reset
REQ-030 With rst_n low at a clk edge, SHALL enter IDLE, set the synchronizer flops to 1, and clear all counters.
REQ-031 On reset, rx_data SHALL be 0, rx_valid 0, rx_perr 0, rx_ferr 0 and overrun 0.
REQ-032 A reset asserted mid-frame SHALL abort the frame with no output; after release, SHALL wait for a fresh falling edge.

Structure
REQ-033 Package uart_pkg SHALL hold the FSM state enum, the parity_mode enum and the constants OVERSAMPLE=16 and SAMPLE_MID=8.
REQ-034 SHALL instantiate one sub-module, uart_baud_tick, containing the divisor counter, a restart input and a tick output.

Verification
REQ-035 With baud_div=2, 8 data bits, no parity and 1 stop bit, sending 0xA5 SHALL give rx_valid with rx_data=0xA5 and perr=ferr=0, within 10 bit times of the start edge.
REQ-036 With even parity, sending 0x03 with parity bit 1 SHALL give perr=1; with odd parity and parity bit 1, the same byte SHALL give perr=0.
REQ-037 A stop bit held low for a full bit SHALL give ferr=1 with the data delivered; with stop2=1, a low second stop bit SHALL give ferr=1.
REQ-038 A 3-tick low pulse on rx SHALL produce no rx_valid; the following valid frame 0x5A SHALL be received correctly.
REQ-039 With rx_ready=0, two back-to-back frames 0x11 then 0x22 SHALL leave rx_data=0x11 held and pulse overrun once.
REQ-040 Asserting rst_n low during DATA, then sending 0x3C after release, SHALL yield exactly one frame, rx_data=0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receiver.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned SAMPLE_MID = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: one tick every max(div_i,1) cycles, phase reset by restart_i.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] last_c;
  logic             tick_q, tick_d;

  always_comb begin
    last_c = (div_i == '0) ? '0 : div_i - DIV_W'(1);
    cnt_d  = cnt_q + DIV_W'(1);
    tick_d = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q >= last_c) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_os.sv
// 16x oversampling UART receiver with majority-vote sampling, parity/framing
// checks and a single-entry valid/ready output holding register.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop2,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 overrun
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(SAMPLE_MID - 1);
  localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(SAMPLE_MID);
  localparam logic [TICK_W-1:0] TICK_S2   = TICK_W'(SAMPLE_MID + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  // Synchronizer and edge-detect arming; arm_q needs a real high sample after
  // reset so a line already low at release is not mistaken for a start edge.
  logic       sync1_q, sync2_q, rx_prev_q, arm_q;
  logic [1:0] fill_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
      fill_q    <= 2'b00;
      arm_q     <= 1'b0;
    end else begin
      sync1_q   <= rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
      fill_q    <= {fill_q[0], 1'b1};
      if (fill_q[1] && sync2_q) arm_q <= 1'b1;
    end
  end

  rx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_idx_q, tick_idx_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 fperr_q, fperr_d;
  logic                 fferr_q, fferr_d;
  logic [DIV_W-1:0]     div_q, div_d;
  parity_e              par_q, par_d;
  logic                 stop2_q, stop2_d;

  logic start_edge_c, tick, maj_c, done_c, par_en_c;
  logic at_s0, at_s1, at_s2, at_last;

  assign start_edge_c = (state_q == ST_IDLE) && arm_q && rx_prev_q && !sync2_q;
  assign at_s0        = (tick_idx_q == TICK_S0);
  assign at_s1        = (tick_idx_q == TICK_S1);
  assign at_s2        = (tick_idx_q == TICK_S2);
  assign at_last      = (tick_idx_q == TICK_LAST);
  assign par_en_c     = (par_q == PAR_EVEN) || (par_q == PAR_ODD);

  uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (start_edge_c),
    .div_i     (div_q),
    .tick_o    (tick)
  );

  always_comb begin
    state_d    = state_q;
    tick_idx_d = tick_idx_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    fperr_d    = fperr_q;
    fferr_d    = fferr_q;
    div_d      = div_q;
    par_d      = par_q;
    stop2_d    = stop2_q;
    done_c     = 1'b0;
    maj_c      = maj3(samp_q[0], samp_q[1], sync2_q);

    if (state_q == ST_IDLE) begin
      if (start_edge_c) begin
        state_d    = ST_START;
        tick_idx_d = '0;
        bit_idx_d  = '0;
        stop_idx_d = 1'b0;
        fperr_d    = 1'b0;
        fferr_d    = 1'b0;
        div_d      = baud_div;
        par_d      = parity_e'(parity_mode);
        stop2_d    = stop2;
      end
    end else if (tick) begin
      tick_idx_d = at_last ? '0 : tick_idx_q + 1'b1;
      if (at_s0) samp_d[0] = sync2_q;
      if (at_s1) samp_d[1] = sync2_q;
      case (state_q)
        ST_START: begin
          if (at_s2 && maj_c) state_d = ST_IDLE;
          else if (at_last)   state_d = ST_DATA;
        end
        ST_DATA: begin
          if (at_s2) shift_d = {maj_c, shift_q[DATA_BITS-1:1]};
          if (at_last) begin
            if (bit_idx_q == BIT_LAST) begin
              bit_idx_d = '0;
              state_d   = par_en_c ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (at_s2) fperr_d = (^shift_q) ^ maj_c ^ (par_q == PAR_ODD);
          if (at_last) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (at_s2) begin
            if (!maj_c) fferr_d = 1'b1;
            if (stop_idx_q == stop2_q) begin
              done_c  = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (at_last) begin
            stop_idx_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tick_idx_q <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      samp_q     <= '0;
      shift_q    <= '0;
      fperr_q    <= 1'b0;
      fferr_q    <= 1'b0;
      div_q      <= '0;
      par_q      <= PAR_NONE;
      stop2_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_idx_q <= tick_idx_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      fperr_q    <= fperr_d;
      fferr_q    <= fferr_d;
      div_q      <= div_d;
      par_q      <= par_d;
      stop2_q    <= stop2_d;
    end
  end

  // Output holding register: a completed frame loads only if the slot is free
  // or being drained this cycle, otherwise it is dropped with an overrun pulse.
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (done_c) begin
      if (!valid_q || rx_ready) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        perr_d  = fperr_q;
        ferr_d  = fferr_q | ~maj_c;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data  = data_q;
  assign rx_valid = valid_q;
  assign rx_perr  = perr_q;
  assign rx_ferr  = ferr_q;
  assign overrun  = ovr_q;

endmodule
